// File: rtl/an_decode_sched.sv
// Round-robin front end sharing one iterative AN-code (A=37) single-error-correcting
// decoder: bit-serial residue, +/-2^k syndrome search, correction, restoring divide.
module an_decode_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 18,
  parameter int unsigned NW   = 12,
  parameter int unsigned A    = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NW-1:0]            out_n,
  output logic [$clog2(NREQ)-1:0]  out_id,
  output logic                     out_corrected,
  output logic                     out_err
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned RW  = $clog2(A);     // residues are < A
  localparam int unsigned DW  = RW + 1;        // residue shifted by one bit
  localparam int unsigned CW  = $clog2(W + 1);
  localparam int unsigned KW  = $clog2(W);
  localparam int unsigned EW  = W + 2;         // correction with sign and overflow bits
  localparam logic [RW-1:0] A_R = RW'(A);
  localparam logic [DW-1:0] A_D = DW'(A);

  typedef enum logic [2:0] {
    S_IDLE, S_RESID, S_SEARCH, S_CORR, S_DIV, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [W-1:0]    word_q, word_d;
  logic [RW-1:0]   r_q, r_d;
  logic [RW-1:0]   p_q, p_d;
  logic [KW-1:0]   k_q, k_d;
  logic            sub_q, sub_d;
  logic            fix_q, fix_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic [NW-1:0]   out_n_q, out_n_d;
  logic [IDW-1:0]  out_id_q, out_id_d;
  logic            out_corr_q, out_corr_d;
  logic            out_err_q, out_err_d;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  cand;

  // Shared modular step: (2x + bit) mod A, one conditional subtract suffices.
  logic [DW-1:0] r_ext, d_ext, p_ext;
  logic [RW-1:0] r_step, d_step, p_step;
  logic          d_ge;
  logic [W-1:0]  quot;
  logic [EW-1:0] ext, delta, corr_res;

  assign r_ext  = {r_q, word_q[W-1]};
  assign r_step = (r_ext >= A_D) ? RW'(r_ext - A_D) : RW'(r_ext);
  assign d_ext  = {rem_q, word_q[W-1]};
  assign d_ge   = (d_ext >= A_D);
  assign d_step = d_ge ? RW'(d_ext - A_D) : RW'(d_ext);
  assign p_ext  = {p_q, 1'b0};
  assign p_step = (p_ext >= A_D) ? RW'(p_ext - A_D) : RW'(p_ext);
  assign quot   = {word_q[W-2:0], d_ge};

  assign ext      = {2'b00, word_q};
  assign delta    = EW'(1) << k_q;
  assign corr_res = !fix_q ? ext : (sub_q ? ext - delta : ext + delta);

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin : p_grant
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(rr_ptr_q) + i) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin : p_next
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    word_d      = word_q;
    r_d         = r_q;
    p_d         = p_q;
    k_d         = k_q;
    sub_d       = sub_q;
    fix_d       = fix_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_n_d     = out_n_q;
    out_id_d    = out_id_q;
    out_corr_d  = out_corr_q;
    out_err_d   = out_err_q;
    req_ready   = '0;

    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready = rst ? '0 : (NREQ'(1) << gnt_idx);
          id_d      = gnt_idx;
          word_d    = req_data[32'(gnt_idx) * W +: W];
          rr_ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          r_d       = '0;
          p_d       = RW'(1);
          k_d       = '0;
          sub_d     = 1'b0;
          fix_d     = 1'b0;
          cnt_d     = '0;
          rem_d     = '0;
          err_d     = 1'b0;
          state_d   = S_RESID;
        end
      end

      // Rotation leaves the word intact after W steps.
      S_RESID: begin
        r_d    = r_step;
        word_d = {word_q[W-2:0], word_q[W-1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          cnt_d   = '0;
          state_d = S_SEARCH;
        end
      end

      S_SEARCH: begin
        state_d = S_CORR;
        if (r_q == '0) begin
          fix_d = 1'b0;
        end else if (p_q == r_q) begin
          fix_d = 1'b1;
          sub_d = 1'b1;
        end else if (p_q == A_R - r_q) begin
          fix_d = 1'b1;
          sub_d = 1'b0;
        end else if (k_q == KW'(W - 1)) begin
          err_d = 1'b1;
        end else begin
          k_d     = k_q + KW'(1);
          p_d     = p_step;
          state_d = S_SEARCH;
        end
      end

      S_CORR: begin
        word_d = corr_res[W-1:0];
        if (corr_res[W+1] || corr_res[W]) err_d = 1'b1;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end

      // Quotient bits shift in where dividend bits shift out.
      S_DIV: begin
        rem_d  = d_step;
        word_d = quot;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_err_d   = err_q | (|quot[W-1:NW]);
          out_n_d     = (err_q | (|quot[W-1:NW])) ? '0 : quot[NW-1:0];
          out_id_d    = id_q;
          out_corr_d  = (r_q != '0);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      word_q      <= '0;
      r_q         <= '0;
      p_q         <= '0;
      k_q         <= '0;
      sub_q       <= 1'b0;
      fix_q       <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
      out_id_q    <= '0;
      out_corr_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      word_q      <= word_d;
      r_q         <= r_d;
      p_q         <= p_d;
      k_q         <= k_d;
      sub_q       <= sub_d;
      fix_q       <= fix_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
      out_id_q    <= out_id_d;
      out_corr_q  <= out_corr_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_n         = out_n_q;
  assign out_id        = out_id_q;
  assign out_corrected = out_corr_q;
  assign out_err       = out_err_q;

endmodule

// File: tb/tb_an_decode_sched.sv
// Randomized bench for an_decode_sched against a divisibility-search reference
// model and a round-robin grant model.
module tb_an_decode_sched;

  localparam int NREQ = 4;
  localparam int W    = 18;
  localparam int NW   = 12;
  localparam int A    = 37;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [NW-1:0]     out_n;
  logic [IDW-1:0]    out_id;
  logic              out_corrected;
  logic              out_err;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_ptr  = 0;
  bit          vld[NREQ];
  logic [W-1:0] dat[NREQ];

  an_decode_sched dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_n         (out_n),
    .out_id        (out_id),
    .out_corrected (out_corrected),
    .out_err       (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = vld[i];
      req_data[i*W +: W]    = dat[i];
    end
  endtask

  // Decode = smallest k for which cw -/+ 2^k is a multiple of A, then divide.
  function automatic void model(input logic [W-1:0] cw, output int n, output bit corr,
                                output bit err, output int lat);
    longint c, v, d, q;
    bit found;
    int s;
    c = longint'(cw);
    v = c;
    s = 1;
    found = 1'b0;
    corr = (c % A) != 0;
    if (corr) begin
      for (int k = 0; k < W; k++) begin
        if (!found) begin
          d = longint'(1) << k;
          if (((c - d) % A) == 0) begin
            v = c - d; s = k + 1; found = 1'b1;
          end else if (((c + d) % A) == 0) begin
            v = c + d; s = k + 1; found = 1'b1;
          end
        end
      end
    end
    err = corr && !found;
    if (v < 0 || v >= (longint'(1) << W)) err = 1'b1;
    q = v / A;
    if (q > (longint'(1) << NW) - 1) err = 1'b1;
    n = err ? 0 : int'(q);
    lat = 2 * W + 1 + s;
  endfunction

  function automatic logic [W-1:0] gen_word();
    longint v;
    int unsigned q, k, mode;
    q    = $urandom_range(0, 4095);
    k    = $urandom_range(0, W - 1);
    mode = $urandom_range(0, 4);
    v    = longint'(q) * A;
    case (mode)
      1: v = v + (longint'(1) << k);
      2: v = v - (longint'(1) << k);
      3: v = longint'($urandom_range(0, 5095)) * A;
      4: v = longint'($urandom);
      default: ;
    endcase
    return W'(v);
  endfunction

  // One grant/decode/handshake; keep_port stays valid with fresh data after its grant.
  task automatic serve(input int keep_port, input int stall);
    int g, en, el, cyc;
    bit ec, ee;
    logic [W-1:0] cw;
    g = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (vld[(rr_ptr + i) % NREQ]) g = (rr_ptr + i) % NREQ;
    end
    apply();
    #1;
    check("grant", 64'(req_ready), 64'(4'(1) << g));
    cw = dat[g];
    model(cw, en, ec, ee, el);
    rr_ptr = (g + 1) % NREQ;
    tick();
    if (g == keep_port) dat[g] = gen_word();
    else vld[g] = 1'b0;
    apply();
    check("ready_busy", 64'(req_ready), 64'(0));
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    check("latency", 64'(cyc), 64'(el));
    check("out_n", 64'(out_n), 64'(en));
    check("out_id", 64'(out_id), 64'(g));
    check("out_corrected", 64'(out_corrected), 64'(ec));
    check("out_err", 64'(out_err), 64'(ee));
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_n", 64'(out_n), 64'(en));
      check("stall_ready", 64'(req_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'(0));
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1'b0;
      dat[i] = '0;
    end
    apply();
    repeat (3) tick();
    vld[0] = 1'b1;
    apply();
    #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_n", 64'(out_n), 64'(0));
    check("rst_id", 64'(out_id), 64'(0));
    check("rst_corr", 64'(out_corrected), 64'(0));
    check("rst_err", 64'(out_err), 64'(0));
    vld[0] = 1'b0;
    apply();
    rst = 1'b0;
    rr_ptr = 0;
    repeat (3) begin
      tick();
      check("idle_ready", 64'(req_ready), 64'(0));
      check("idle_valid", 64'(out_valid), 64'(0));
    end

    // Clean word, +bit0, -bit0, bit17 error on ports 0..3
    dat[0] = 18'd20868;  vld[0] = 1'b1; serve(-1, 0);
    dat[1] = 18'd20869;  vld[1] = 1'b1; serve(-1, 0);
    dat[2] = 18'd20867;  vld[2] = 1'b1; serve(-1, 0);
    dat[3] = 18'd151940; vld[3] = 1'b1; serve(-1, 0);

    // All ports together; port 1 stays valid and must wait behind 2 and 3
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1'b1;
      dat[i] = 18'(20868 + (1 << i));
    end
    repeat (5) serve(1, 0);
    vld[1] = 1'b0;

    // Uncorrectable: correction out of range, then quotient overflow
    dat[0] = 18'd262143; vld[0] = 1'b1; serve(-1, 0);
    dat[0] = 18'd185000; vld[0] = 1'b1; serve(-1, 0);

    // Consumer stall with another request pending, then immediate next grant
    dat[2] = 18'd20869; vld[2] = 1'b1;
    dat[3] = 18'd20868; vld[3] = 1'b1;
    serve(-1, 10);
    serve(-1, 0);

    // Reset in the middle of division
    dat[2] = 18'd20869; vld[2] = 1'b1;
    apply();
    #1;
    check("pre_rst_grant", 64'(req_ready), 64'(4'b0100));
    tick();
    vld[2] = 1'b0;
    apply();
    repeat (30) tick();
    check("in_div_valid", 64'(out_valid), 64'(0));
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_n", 64'(out_n), 64'(0));
    check("arst_id", 64'(out_id), 64'(0));
    check("arst_corr", 64'(out_corrected), 64'(0));
    check("arst_err", 64'(out_err), 64'(0));
    check("arst_ready", 64'(req_ready), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    rr_ptr = 0;
    dat[0] = gen_word(); vld[0] = 1'b1;
    dat[3] = gen_word(); vld[3] = 1'b1;
    serve(-1, 0);
    serve(-1, 0);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i] && $urandom_range(0, 1) == 1) begin
          vld[i] = 1'b1;
          dat[i] = gen_word();
        end
      end
      if (!(vld[0] || vld[1] || vld[2] || vld[3])) begin
        vld[it % NREQ] = 1'b1;
        dat[it % NREQ] = gen_word();
      end
      serve(int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/an_decode_sched.md
# an_decode_sched

Round-robin scheduler and iterative sequencer that shares one AN-code (A=37) single-error-correcting decode engine among several requesters. The block accepts 18-bit received codewords, computes the residue mod A bit-serially, and searches for the matching ±2^k syndrome. It then corrects the word and divides by A to recover the 12-bit data word N. It sits between the codeword producers and the data consumer, replacing one combinational decoder per requester.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 18, codeword width
- NW, 12, decoded data width
- A, 37, code constant; must be odd, with the multiplicative order of 2 mod A equal to 2*W (true for 37/18)
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req_valid  in  NREQ  per-requester codeword valid
- req_data  in  NREQ*W  codeword of requester i at bits [i*W +: W]
- req_ready  out  NREQ  one-hot acceptance pulse
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_n  out  NW  decoded N
- out_id  out  clog2(NREQ)  requester index of this result
- out_corrected  out  1  a single-bit error was corrected
- out_err  out  1  uncorrectable: correction out of range or quotient > 2^NW-1

## Operation
- States: IDLE, RESID, SEARCH, CORR, DIV, DONE.
- IDLE:
  - If any req_valid is high, grant the first valid index at or after rr_ptr, wrapping.
  - Assert req_ready[g] for that cycle and capture req_data[g] and g.
  - Set rr_ptr = (g+1) mod NREQ and go to RESID.
  - With no req_valid, stay in IDLE.
- RESID: W cycles, MSB first, computing r = (2r + bit) mod A. r starts at 0. Then go to SEARCH.
- SEARCH:
  - If r == 0: 1 cycle, no correction, go to CORR.
  - Otherwise, keep p = 2^k mod A, with k starting at 0 and p at 1. Each cycle:
    - if p == r: the error is +2^k, so subtract 2^k;
    - else if p == A-r: the error is -2^k, so add 2^k;
    - else set k = k+1 and p = 2p mod A.
  - A match exits in cycle k+1. A match always occurs by k = W-1 for legal A.
- CORR: 1 cycle.
  - Apply the correction in W+1 bits.
  - A result < 0 or ≥ 2^W sets err.
  - out_corrected = (r != 0).
- DIV: W cycles of restoring division of the corrected word by A, producing quotient q (W bits).
  - The remainder is always 0 when there is no err.
  - If q > 2^NW-1, set err.
- DONE:
  - Hold out_valid = 1 and stable outputs until out_ready.
  - On out_valid && out_ready, go to IDLE.
  - out_n = q[NW-1:0] if no err, else 0.
- Only one word is in flight at a time. All req_ready are 0 outside the IDLE grant cycle.
- Reset (asynchronous, any state, including mid-decode):
  - state IDLE, rr_ptr 0;
  - req_ready 0, out_valid 0, out_n 0, out_id 0, out_corrected 0, out_err 0.
  - Any in-flight word is discarded; no result is produced for it.

## Timing
- The grant is combinational from req_valid and rr_ptr in IDLE. Capture happens on that edge (edge 0).
- Latency: out_valid rises after edge 0 + W + S + 1 + W, where S = 1 (r==0) or k+1.
  - For W=18: 38 + S - 1 edges, so 38 cycles for an error-free word.
- Worst case: S = 18, giving 55 cycles.
- A result at out_valid && out_ready returns to IDLE. The next grant is possible in the following cycle (no same-cycle re-grant).
- A requester that drops req_valid before its grant is not served. A requester may change req_data freely except in its grant cycle.
- out_ready held low: DONE persists indefinitely and no new request is accepted.

## Test plan
- Reset, then a single request on port 0 with 20868 (37*564) -> out_valid after 38 cycles; out_n=564, out_id=0, corrected=0, err=0.
- Port 1 sends 20869 (R=1, +bit0) -> out_n=564, corrected=1. Port 2 sends 20867 (R=36, -bit0) -> out_n=564, corrected=1. Port 3 sends 151940 (R=18, bit17) -> out_n=564, corrected=1, with latency 38+17 cycles.
- All four ports valid simultaneously after reset with distinct words -> req_ready pulses in order 0,1,2,3. Each result carries its matching out_id. With port 1 held valid continuously, it is next served only after ports 2 and 3.
- Port 0 sends 262143 (R=35, would add 2^1 giving 262145) -> err=1, out_n=0. Port 0 sends 185000 (37*5000) -> quotient overflow, err=1, out_n=0.
- out_ready held low for 10 cycles in DONE -> outputs stable and no req_ready. Release -> IDLE, then the next grant in the following cycle.
- rst asserted mid-DIV -> all outputs 0 immediately (asynchronous). After release, a new request decodes correctly and rr_ptr restarts at 0.
